// File: rtl/alu_shift_sched.sv
// Issue scheduler for the shared 64-bit shift datapath.
// Each of ports A and B has a one-entry request buffer. A round-robin arbiter
// picks one full buffer per cycle and launches it on the registered sh_* bus.
// One cycle after launch, sh_done/sh_done_tag line up with the shifter flag
// stage. A flush (except) removes buffered and in-flight work of one thread.
module alu_shift_sched #(
  parameter int TAG_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 except,
  input  logic                 except_thread,
  // port A
  input  logic                 reqA_vld,
  output logic                 reqA_rdy,
  input  logic                 reqA_thr,
  input  logic [TAG_WIDTH-1:0] reqA_tag,
  input  logic [3:0]           reqA_sz,
  input  logic                 reqA_arith,
  input  logic                 reqA_dir,
  input  logic [5:0]           reqA_cnt,
  input  logic [63:0]          reqA_val,
  // port B
  input  logic                 reqB_vld,
  output logic                 reqB_rdy,
  input  logic                 reqB_thr,
  input  logic [TAG_WIDTH-1:0] reqB_tag,
  input  logic [3:0]           reqB_sz,
  input  logic                 reqB_arith,
  input  logic                 reqB_dir,
  input  logic [5:0]           reqB_cnt,
  input  logic [63:0]          reqB_val,
  // shifter launch bus
  output logic                 sh_go,
  output logic [3:0]           sh_sz,
  output logic                 sh_arith,
  output logic                 sh_dir,
  output logic [5:0]           sh_cnt,
  output logic [63:0]          sh_val,
  output logic [TAG_WIDTH-1:0] sh_tag,
  // completion, aligned with the shifter flag stage
  output logic                 sh_done,
  output logic [TAG_WIDTH-1:0] sh_done_tag,
  output logic                 busy
);

  typedef struct packed {
    logic                 thr;
    logic [TAG_WIDTH-1:0] tag;
    logic [3:0]           sz;
    logic                 arith;
    logic                 dir;
    logic [5:0]           cnt;
    logic [63:0]          val;
  } req_t;

  req_t       a_in, b_in;
  req_t       a_buf, b_buf;
  logic       a_full, b_full;
  logic       rr_b;          // 1: port B was granted last, so A wins a tie
  logic       sh_thr;        // thread of the op currently on the sh_go stage

  logic       a_kill, b_kill;
  logic       a_cand, b_cand;
  logic       gnt_a, gnt_b;
  logic       a_acc, b_acc;
  req_t       win;
  logic [5:0] win_cnt;
  logic       go_killed;

  assign a_in = '{thr: reqA_thr, tag: reqA_tag, sz: reqA_sz, arith: reqA_arith,
                  dir: reqA_dir, cnt: reqA_cnt, val: reqA_val};
  assign b_in = '{thr: reqB_thr, tag: reqB_tag, sz: reqB_sz, arith: reqB_arith,
                  dir: reqB_dir, cnt: reqB_cnt, val: reqB_val};

  // Flush qualification, round-robin grant and selection of the launched request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_kill    = 1'b0;
    b_kill    = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    win       = b_buf;
    win_cnt   = 6'd0;
    go_killed = 1'b0;

    a_kill = except & a_full & (a_buf.thr == except_thread);
    b_kill = except & b_full & (b_buf.thr == except_thread);
    a_cand = a_full & ~a_kill;
    b_cand = b_full & ~b_kill;

    // Single candidate wins outright; on a tie the port opposite the pointer wins.
    gnt_a = a_cand & (~b_cand | rr_b);
    gnt_b = b_cand & (~a_cand | ~rr_b);

    if (gnt_a) win = a_buf;
    // Narrow ops only use the low five count bits.
    win_cnt = win.sz[3] ? win.cnt : {1'b0, win.cnt[4:0]};

    go_killed = except & (sh_thr == except_thread);
  end

  // Ready comes from buffer state and grant only, never from the incoming valid.
  assign reqA_rdy = ~a_full | gnt_a;
  assign reqB_rdy = ~b_full | gnt_b;

  // A handshake on the thread being flushed is taken but discarded.
  assign a_acc = reqA_vld & reqA_rdy & ~(except & (reqA_thr == except_thread));
  assign b_acc = reqB_vld & reqB_rdy & ~(except & (reqB_thr == except_thread));

  // Buffer occupancy: refill beats grant/flush so a port sustains one request per cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
    end else begin
      if (a_acc)                a_full <= 1'b1;
      else if (gnt_a || a_kill) a_full <= 1'b0;
      if (b_acc)                b_full <= 1'b1;
      else if (gnt_b || b_kill) b_full <= 1'b0;
    end
  end

  // Buffer payload capture on an accepted request.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; the full flags alone say whether it is meaningful.
    if (a_acc) a_buf <= a_in;
    if (b_acc) b_buf <= b_in;
  end

  // Round-robin pointer tracks the most recently granted port.
  always_ff @(posedge clk) begin
    if (rst)        rr_b <= 1'b1;
    else if (gnt_a) rr_b <= 1'b0;
    else if (gnt_b) rr_b <= 1'b1;
  end

  // Launch stage: strobe every cycle, fields only reload on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_go    <= 1'b0;
      sh_sz    <= 4'd0;
      sh_arith <= 1'b0;
      sh_dir   <= 1'b0;
      sh_cnt   <= 6'd0;
      sh_val   <= 64'd0;
      sh_tag   <= '0;
      sh_thr   <= 1'b0;
    end else begin
      sh_go <= gnt_a | gnt_b;
      if (gnt_a || gnt_b) begin
        sh_sz    <= win.sz;
        sh_arith <= win.arith;
        sh_dir   <= win.dir;
        sh_cnt   <= win_cnt;
        sh_val   <= win.val;
        sh_tag   <= win.tag;
        sh_thr   <= win.thr;
      end
    end
  end

  // Completion stage: an op flushed while on sh_go never reports done.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_done     <= 1'b0;
      sh_done_tag <= '0;
    end else begin
      sh_done <= sh_go & ~go_killed;
      if (sh_go && !go_killed) sh_done_tag <= sh_tag;
    end
  end

  assign busy = a_full | b_full | sh_go | sh_done;

endmodule

// File: tb/tb_alu_shift_sched.sv
// Self-checking bench for alu_shift_sched: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_alu_shift_sched;

  localparam int TW = 9;

  typedef struct {
    logic          thr;
    logic [TW-1:0] tag;
    logic [3:0]    sz;
    logic          arith;
    logic          dir;
    logic [5:0]    cnt;
    logic [63:0]   val;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, except, except_thread;
  logic          va, vb;
  req_t          ia, ib;
  logic          reqA_rdy, reqB_rdy;
  logic          sh_go, sh_arith, sh_dir, sh_done, busy;
  logic [3:0]    sh_sz;
  logic [5:0]    sh_cnt;
  logic [63:0]   sh_val;
  logic [TW-1:0] sh_tag, sh_done_tag;

  alu_shift_sched #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
    .reqA_vld(va), .reqA_rdy(reqA_rdy), .reqA_thr(ia.thr), .reqA_tag(ia.tag),
    .reqA_sz(ia.sz), .reqA_arith(ia.arith), .reqA_dir(ia.dir), .reqA_cnt(ia.cnt),
    .reqA_val(ia.val),
    .reqB_vld(vb), .reqB_rdy(reqB_rdy), .reqB_thr(ib.thr), .reqB_tag(ib.tag),
    .reqB_sz(ib.sz), .reqB_arith(ib.arith), .reqB_dir(ib.dir), .reqB_cnt(ib.cnt),
    .reqB_val(ib.val),
    .sh_go(sh_go), .sh_sz(sh_sz), .sh_arith(sh_arith), .sh_dir(sh_dir),
    .sh_cnt(sh_cnt), .sh_val(sh_val), .sh_tag(sh_tag),
    .sh_done(sh_done), .sh_done_tag(sh_done_tag), .busy(busy)
  );

  // Reference model: per-port pending request, last-granted port, launch record.
  bit            m_full [2];
  req_t          m_buf  [2];
  int            m_last;
  bit            m_go;
  req_t          m_sh;
  bit            m_done;
  logic [TW-1:0] m_done_tag;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_last = 1;
    m_go = 0; m_done = 0; m_done_tag = '0;
    m_sh = '{thr: 1'b0, tag: '0, sz: 4'd0, arith: 1'b0, dir: 1'b0, cnt: 6'd0, val: 64'd0};
  endtask

  task automatic idle_inputs();
    va = 0; vb = 0; except = 0; except_thread = 0;
  endtask

  task automatic set_req(input int p, input logic thr, input int tag, input logic [3:0] sz,
                         input logic [5:0] cnt, input logic [63:0] val);
    req_t r;
    r = '{thr: thr, tag: TW'(tag), sz: sz, arith: 1'b0, dir: 1'b1, cnt: cnt, val: val};
    if (p == 0) begin ia = r; va = 1; end
    else        begin ib = r; vb = 1; end
  endtask

  // One clock: inputs are already applied (at the negedge). Check ready, step
  // the model across the edge, then check every registered output.
  task automatic cycle();
    bit   kill [2];
    bit   cand [2];
    bit   rdy  [2];
    bit   vld  [2];
    req_t inr  [2];
    int   g;
    #1;
    vld[0] = va; vld[1] = vb; inr[0] = ia; inr[1] = ib;
    for (int p = 0; p < 2; p++) begin
      kill[p] = except && m_full[p] && (m_buf[p].thr == except_thread);
      cand[p] = m_full[p] && !kill[p];
    end
    if (cand[0] && cand[1]) g = (m_last == 1) ? 0 : 1;
    else if (cand[0])       g = 0;
    else if (cand[1])       g = 1;
    else                    g = -1;
    for (int p = 0; p < 2; p++) rdy[p] = !m_full[p] || (g == p);
    chk("rdyA", 64'(reqA_rdy), 64'(rdy[0]));
    chk("rdyB", 64'(reqB_rdy), 64'(rdy[1]));

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_go && !(except && m_sh.thr == except_thread)) begin
        m_done = 1; m_done_tag = m_sh.tag;
      end else begin
        m_done = 0;
      end
      if (g >= 0) begin
        m_go = 1;
        m_sh = m_buf[g];
        if (!m_sh.sz[3]) m_sh.cnt = 6'(m_sh.cnt % 6'd32);
        m_last = g;
      end else begin
        m_go = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (g == p || kill[p]) m_full[p] = 0;
        if (vld[p] && rdy[p] && !(except && inr[p].thr == except_thread)) begin
          m_full[p] = 1; m_buf[p] = inr[p];
        end
      end
    end

    #1;
    chk("sh_go",    64'(sh_go),    64'(m_go));
    chk("sh_tag",   64'(sh_tag),   64'(m_sh.tag));
    chk("sh_sz",    64'(sh_sz),    64'(m_sh.sz));
    chk("sh_arith", 64'(sh_arith), 64'(m_sh.arith));
    chk("sh_dir",   64'(sh_dir),   64'(m_sh.dir));
    chk("sh_cnt",   64'(sh_cnt),   64'(m_sh.cnt));
    chk("sh_val",   sh_val,        m_sh.val);
    chk("sh_done",  64'(sh_done),  64'(m_done));
    if (m_done) chk("sh_done_tag", 64'(sh_done_tag), 64'(m_done_tag));
    chk("busy", 64'(busy), 64'(m_full[0] || m_full[1] || m_go || m_done));
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  initial begin
    logic [TW-1:0] prev_tag;
    bit            prev_go;
    rst = 1;
    idle_inputs();
    ia = '{thr: 1'b0, tag: '0, sz: 4'd0, arith: 1'b0, dir: 1'b0, cnt: 6'd0, val: 64'd0};
    ib = ia;
    model_reset();
    @(negedge clk);

    // Reset state
    cycle();
    cycle();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sh_done_tag", 64'(sh_done_tag), 64'd0);
    rst = 0;

    // A only: tag 5, 64-bit, count 3
    set_req(0, 0, 5, 4'hF, 6'd3, 64'h0123_4567_89AB_CDEF);
    cycle();
    va = 0;
    cycle();
    chk("a_only_go", 64'(sh_go), 64'd1);
    chk("a_only_tag", 64'(sh_tag), 64'd5);
    chk("a_only_cnt", 64'(sh_cnt), 64'd3);
    cycle();
    chk("a_only_done", 64'(sh_done), 64'd1);
    chk("a_only_done_tag", 64'(sh_done_tag), 64'd5);
    cycle();

    // A and B together after reset: A first
    do_reset();
    set_req(0, 0, 1, 4'hF, 6'd1, 64'h11);
    set_req(1, 1, 2, 4'hF, 6'd2, 64'h22);
    cycle();
    idle_inputs();
    cycle();
    chk("tie_first_tag", 64'(sh_tag), 64'd1);
    cycle();
    chk("tie_second_tag", 64'(sh_tag), 64'd2);
    chk("tie_first_done", 64'(sh_done_tag), 64'd1);
    cycle();
    chk("tie_second_done", 64'(sh_done_tag), 64'd2);
    cycle();

    // Both ports held valid: launches alternate
    set_req(0, 0, 3, 4'hF, 6'd7, 64'hAAAA);
    set_req(1, 1, 4, 4'h7, 6'd9, 64'hBBBB);
    prev_go = 0;
    prev_tag = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (prev_go && sh_go) chk("alternate", 64'(sh_tag != prev_tag), 64'd1);
      prev_go = sh_go;
      prev_tag = sh_tag;
    end
    idle_inputs();
    cycle(); cycle(); cycle();

    // Count rule for narrow and wide ops
    set_req(0, 0, 6, 4'h7, 6'd40, 64'h5);
    cycle(); va = 0; cycle();
    chk("cnt_narrow", 64'(sh_cnt), 64'd8);
    set_req(0, 0, 7, 4'hF, 6'd40, 64'h5);
    cycle(); va = 0; cycle();
    chk("cnt_wide", 64'(sh_cnt), 64'd40);
    set_req(0, 0, 8, 4'h1, 6'd0, 64'h5);
    cycle(); va = 0; cycle();
    chk("cnt_zero_go", 64'(sh_go), 64'd1);
    cycle(); cycle();

    // Flush of thread 0: A in sh_go stage, B buffered; thread-1 op survives
    do_reset();
    set_req(0, 0, 10, 4'hF, 6'd1, 64'h10);
    set_req(1, 0, 11, 4'hF, 6'd1, 64'h11);
    cycle();
    idle_inputs();
    cycle();
    chk("flush_a_launched", 64'(sh_tag), 64'd10);
    except = 1; except_thread = 0;
    set_req(0, 1, 12, 4'hF, 6'd2, 64'h12);
    cycle();
    idle_inputs();
    chk("flush_b_not_launched", 64'(sh_go), 64'd0);
    chk("flush_a_no_done", 64'(sh_done), 64'd0);
    cycle();
    chk("flush_thr1_launched", 64'(sh_tag), 64'd12);
    cycle();
    chk("flush_thr1_done", 64'(sh_done_tag), 64'd12);
    cycle(); cycle();

    // Reset the cycle after a grant
    do_reset();
    set_req(0, 0, 13, 4'hF, 6'd1, 64'h13);
    cycle();
    va = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_no_done", 64'(sh_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(reqA_rdy), 64'd1);
    cycle();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      ia = '{thr: 1'($urandom_range(0, 1)), tag: TW'($urandom), sz: 4'($urandom),
             arith: 1'($urandom_range(0, 1)), dir: 1'($urandom_range(0, 1)),
             cnt: 6'($urandom), val: {$urandom, $urandom}};
      ib = '{thr: 1'($urandom_range(0, 1)), tag: TW'($urandom), sz: 4'($urandom),
             arith: 1'($urandom_range(0, 1)), dir: 1'($urandom_range(0, 1)),
             cnt: 6'($urandom), val: {$urandom, $urandom}};
      except = ($urandom_range(0, 7) == 0);
      except_thread = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
